logic_unit_pipe: RTL
====================

LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits, legal range 1..64.
REQ-002 Parameter DEPTH, default 4: result-queue entries, a power of two, legal range 2..16.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 in_valid  input  1  operand/op presented.
REQ-006 in_ready  output  1  block can accept a transaction this cycle.
REQ-007 op  input  3  operation select: 0 AND, 1 OR, 2 NOT a, 3 NAND, 4 NOR, 5 XOR, 6 XNOR, 7 PASS a.
REQ-008 a  input  WIDTH  operand A.
REQ-009 b  input  WIDTH  operand B, ignored for op 2 and op 7.
REQ-010 out_valid  output  1  head result available.
REQ-011 out_ready  input  1  consumer accepts head result.
REQ-012 y  output  WIDTH  head result, bitwise per op.
REQ-013 y_zero  output  1  head result is all zeros.
REQ-014 y_parity  output  1  XOR-reduction of head result.
REQ-015 level  output  $clog2(DEPTH)+1  entries currently queued.
REQ-016 op_count  output  16  accepted-transaction counter (see Configuration).

Function
REQ-017 Push occurs on a rising edge with in_valid=1 and in_ready=1; the result of op applied to a/b sampled that edge is written into the queue tail.
REQ-018 Pop occurs on a rising edge with out_valid=1 and out_ready=1; the head entry is removed.
REQ-019 Latency: a result pushed into an empty queue shall drive out_valid=1 on the cycle after the push edge; no combinational path from a/b/op to y.
REQ-020 in_ready = (level != DEPTH), derived from registers only; no combinational path from out_ready to in_ready.
REQ-021 out_valid = (level != 0).
REQ-022 y, y_zero, y_parity derive from the head entry when out_valid=1; all three are 0 when out_valid=0.
REQ-023 Push and pop on the same edge: level unchanged, both pointers advance.
REQ-024 Full: in_ready=0, an asserted in_valid is ignored and no entry is overwritten, even if a pop occurs that same edge.
REQ-025 Empty: out_ready is ignored, level is not decremented.
REQ-026 Read and write pointers wrap modulo DEPTH; results exit in push order.
REQ-027 While out_valid=1 and out_ready=0, y/y_zero/y_parity hold stable.
REQ-028 y_zero and y_parity are computed at push time and stored alongside the result.

Reset
REQ-029 With rst_n=0 at a rising edge: level=0, pointers=0, op_count=0, out_valid=0, y=0, y_zero=0, y_parity=0.
REQ-030 in_ready=0 in any cycle where rst_n=0; in_ready=1 the first cycle after rst_n returns high.
REQ-031 Reset asserted mid-operation discards all queued entries; no push or pop occurs on a reset edge.

Configuration
REQ-032 Macro LOGIC_UNIT_PIPE_STATS_EN defined: op_count increments by 1 per push, saturates at 16'hFFFF, no wrap.
REQ-033 Macro LOGIC_UNIT_PIPE_STATS_EN undefined: op_count is constant 0; port remains present; no counter logic is built.

Verification
REQ-034 WIDTH=8: push op=0 a=8'hF0 b=8'h3C, out_ready=1 -> next cycle out_valid=1, y=8'h30, y_zero=0, y_parity=0.
REQ-035 Sweep ops 0-7 with a=8'hA5 b=8'h0F -> y = 05, AF, 5A, FA, 50, AA, 55, A5 in order; op=5 with a=b gives y_zero=1.
REQ-036 DEPTH=4, out_ready=0, push 5 transactions -> level=4, in_ready=0 after 4th, 5th not accepted, drained values match first 4 in order.
REQ-037 Queue level 2, simultaneous push and pop for 10 cycles -> level stays 2, pointers wrap, output order preserved.
REQ-038 rst_n=0 for one cycle with level=3 -> level=0, out_valid=0, y=0, op_count=0; in_ready=1 next cycle.
REQ-039 With LOGIC_UNIT_PIPE_STATS_EN: 70000 pushes -> op_count=16'hFFFF; without the macro -> op_count=0 throughout.

Source files
------------

// File: rtl/logic_unit_pipe.sv
// rtl/logic_unit_pipe.sv - bitwise logic unit feeding a DEPTH-entry result queue with valid/ready on both sides
// Optional accepted-transaction counter: define LOGIC_UNIT_PIPE_STATS_EN.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               op,
  input  logic [WIDTH-1:0]         a,
  input  logic [WIDTH-1:0]         b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         y,
  output logic                     y_zero,
  output logic                     y_parity,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              op_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Flags ride along with the data so the output side is a plain register read.
  typedef struct packed {
    logic             parity;
    logic             zero;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [LW-1:0]   count;
  logic            push;
  logic            pop;
  logic [WIDTH-1:0] result;
  entry_t          head;

  always_comb begin
    result = a;
    case (op)
      3'd0:    result = a & b;
      3'd1:    result = a | b;
      3'd2:    result = ~a;
      3'd3:    result = ~(a & b);
      3'd4:    result = ~(a | b);
      3'd5:    result = a ^ b;
      3'd6:    result = ~(a ^ b);
      default: result = a;
    endcase
  end

  // Gating with rst_n keeps in_ready low through reset without touching out_ready.
  assign in_ready  = rst_n & (count != LW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted as valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{parity: ^result, zero: ~|result, data: result};
    end
  end

  assign head     = mem[rd_ptr];
  assign y        = out_valid ? head.data : '0;
  assign y_zero   = out_valid & head.zero;
  assign y_parity = out_valid & head.parity;
  assign level    = count;

`ifdef LOGIC_UNIT_PIPE_STATS_EN
  logic [15:0] ops_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ops_q <= '0;
    end else if (push && ops_q != 16'hFFFF) begin
      ops_q <= ops_q + 16'd1;
    end
  end

  assign op_count = ops_q;
`else
  assign op_count = '0;
`endif

endmodule
